// File: rtl/tdc_measure_ctrl.sv
// Delay-line TDC measurement controller: synchronises the raw tap vector,
// detects the start edge, and turns the captured thermometer code into a timestamp.
module tdc_measure_ctrl #(
    parameter int NTAPS    = 200,
    parameter int COARSE_W = 16,
    parameter int TIMEOUT  = 1024,
    localparam int FINE_W  = $clog2(NTAPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic [NTAPS-1:0]    taps,
    output logic                busy,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                ts_sat,
    output logic                timeout,
    output logic [7:0]          lost_cnt
);

    localparam int NST    = (NTAPS + 3) / 4;
    localparam int PAD_W  = 4 * NST;
    localparam int TCNT_W = 16;

    typedef enum logic [1:0] {IDLE, ARMED, ENCODE, HOLD} state_t;

    state_t                state_reg, state_next;
    logic [NTAPS-1:0]      s1_reg, s2_reg, hold_reg;
    logic                  s3_reg;
    logic [COARSE_W-1:0]   coarse_reg;
    logic [TCNT_W-1:0]     tcnt_reg;
    logic                  hit, expire;
    logic [PAD_W-1:0]      hold_pad;
    logic [2:0]            stage_cnt [NST];
    logic [FINE_W-1:0]     pop_sum;

    assign hit    = s2_reg[0] & ~s3_reg;
    assign expire = (tcnt_reg == TCNT_W'(TIMEOUT - 1));

    // One partial count per CARRY4 stage; bubbles are simply counted, never prioritised.
    assign hold_pad = PAD_W'(hold_reg);
    generate
        for (genvar gi = 0; gi < NST; gi++) begin : g_stage
            assign stage_cnt[gi] = 3'(hold_pad[4*gi])   + 3'(hold_pad[4*gi+1])
                                 + 3'(hold_pad[4*gi+2]) + 3'(hold_pad[4*gi+3]);
        end
    endgenerate

    always_comb begin
        pop_sum = '0;
        for (int i = 0; i < NST; i++) begin
            pop_sum = pop_sum + FINE_W'(stage_cnt[i]);
        end
    end

    always_comb begin
        state_next = state_reg;
        timeout    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arm) state_next = ARMED;
            end
            ARMED: begin
                // A hit in the expiry cycle wins over the timeout.
                if (hit) begin
                    state_next = ENCODE;
                end else if (expire) begin
                    state_next = IDLE;
                    timeout    = ~rst;
                end
            end
            ENCODE: state_next = HOLD;
            HOLD: begin
                if (ts_ready) state_next = arm ? ARMED : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign ts_valid = (state_reg == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            s1_reg     <= '0;
            s2_reg     <= '0;
            s3_reg     <= 1'b0;
            hold_reg   <= '0;
            coarse_reg <= '0;
            tcnt_reg   <= '0;
            ts_coarse  <= '0;
            ts_fine    <= '0;
            ts_sat     <= 1'b0;
            lost_cnt   <= '0;
        end else begin
            s1_reg     <= taps;
            s2_reg     <= s1_reg;
            s3_reg     <= s2_reg[0];
            coarse_reg <= coarse_reg + COARSE_W'(1);
            state_reg  <= state_next;

            if (state_next == ARMED && state_reg != ARMED) begin
                tcnt_reg <= '0;
            end else if (state_reg == ARMED) begin
                tcnt_reg <= tcnt_reg + TCNT_W'(1);
            end

            if (state_reg == ARMED && hit) begin
                hold_reg  <= s2_reg;
                ts_coarse <= coarse_reg;
            end

            if (state_reg == ENCODE) begin
                ts_fine <= pop_sum;
                ts_sat  <= (pop_sum == FINE_W'(NTAPS));
            end

            if ((state_reg == ENCODE || state_reg == HOLD) && hit && lost_cnt != 8'hFF) begin
                lost_cnt <= lost_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Randomised and directed bench for tdc_measure_ctrl against a cycle-level
// behavioural model of the measurement rules.
module tb_tdc_measure_ctrl;

    localparam int NTAPS    = 200;
    localparam int COARSE_W = 16;
    localparam int TIMEOUT  = 16;
    localparam int FINE_W   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arm = 1'b0;
    logic              ts_ready = 1'b0;
    logic [NTAPS-1:0]  taps = '0;

    logic                busy, ts_valid, ts_sat, timeout;
    logic [COARSE_W-1:0] ts_coarse;
    logic [FINE_W-1:0]   ts_fine;
    logic [7:0]          lost_cnt;

    logic                l_busy, l_valid, l_sat, l_timeout;
    logic [COARSE_W-1:0] l_coarse;
    logic [FINE_W-1:0]   l_fine;
    logic [7:0]          l_lost;

    always #5 clk = ~clk;

    tdc_measure_ctrl #(.NTAPS(NTAPS), .COARSE_W(COARSE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .arm(arm), .taps(taps),
        .busy(busy), .ts_valid(ts_valid), .ts_ready(ts_ready),
        .ts_coarse(ts_coarse), .ts_fine(ts_fine), .ts_sat(ts_sat),
        .timeout(timeout), .lost_cnt(lost_cnt)
    );

    // Long-timeout instance for the nominal measurement sequence.
    tdc_measure_ctrl #(.NTAPS(NTAPS), .COARSE_W(COARSE_W), .TIMEOUT(1024)) u_long (
        .clk(clk), .rst(rst), .arm(arm), .taps(taps),
        .busy(l_busy), .ts_valid(l_valid), .ts_ready(ts_ready),
        .ts_coarse(l_coarse), .ts_fine(l_fine), .ts_sat(l_sat),
        .timeout(l_timeout), .lost_cnt(l_lost)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: cycle index since reset, tap sample history, and measurement bookkeeping.
    int               cyc = 0;
    bit               live = 1'b0;
    logic [NTAPS-1:0] h0 = '0, h1 = '0;
    logic             h2b = 1'b0;
    bit               m_armed = 1'b0, m_pend = 1'b0;
    int               m_wait = 0, m_age = 0, m_lost = 0;
    int               e_coarse = 0, e_fine = 0;
    bit               e_sat = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NTAPS-1:0] ones(input int n);
        logic [NTAPS-1:0] v;
        v = '0;
        for (int i = 0; i < NTAPS; i++) if (i < n) v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        logic hit;
        forever begin
            @(posedge clk);
            if (rst) begin
                h0 = '0; h1 = '0; h2b = 1'b0;
                m_armed = 1'b0; m_pend = 1'b0;
                m_wait = 0; m_age = 0; m_lost = 0;
                e_coarse = 0; e_fine = 0; e_sat = 1'b0;
                cyc = 0;
                live = 1'b1;
            end else begin
                hit = h1[0] && !h2b;
                if (m_pend) begin
                    if (hit && m_lost < 255) m_lost++;
                    if (m_age >= 1 && ts_ready) begin
                        m_pend = 1'b0;
                        if (arm) begin m_armed = 1'b1; m_wait = 0; end
                    end else begin
                        m_age++;
                    end
                end else if (m_armed) begin
                    if (hit) begin
                        m_armed  = 1'b0;
                        m_pend   = 1'b1;
                        m_age    = 0;
                        e_coarse = cyc % 65536;
                        e_fine   = $countones(h1);
                        e_sat    = (e_fine == NTAPS);
                    end else if (m_wait == TIMEOUT - 1) begin
                        m_armed = 1'b0;
                    end else begin
                        m_wait++;
                    end
                end else if (arm) begin
                    m_armed = 1'b1;
                    m_wait  = 0;
                end
                h2b = h1[0];
                h1  = h0;
                h0  = taps;
                cyc++;
            end
        end
    end

    always @(negedge clk) begin
        logic hit_now;
        logic vis;
        if (live) begin
            hit_now = h1[0] && !h2b;
            vis     = m_pend && (m_age >= 1);
            chk("busy", busy, m_armed || m_pend);
            chk("ts_valid", ts_valid, vis);
            chk("timeout", timeout, m_armed && (m_wait == TIMEOUT - 1) && !hit_now && !rst);
            chk("lost_cnt", lost_cnt, m_lost);
            if (vis) begin
                chk("ts_coarse", ts_coarse, e_coarse);
                chk("ts_fine", ts_fine, e_fine);
                chk("ts_sat", ts_sat, e_sat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input bit use_long, input int lim, output bit found);
        found = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if ((use_long ? l_valid : ts_valid) == 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               found;
        int               pulse_cyc, pulses, busy_cyc, valids, r;
        logic [NTAPS-1:0] v;

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", ts_valid, 0);
        chk("rst_coarse", ts_coarse, 0);
        chk("rst_fine", ts_fine, 0);
        chk("rst_sat", ts_sat, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_lost", lost_cnt, 0);

        // Nominal measurement: arm at 5, 60-tap step at 20
        taps = '0; ts_ready = 1'b1;
        do_reset();
        goto(5); arm = 1'b1; step(); arm = 1'b0;
        goto(20); taps = ones(60);
        wait_valid(1'b1, 30, found);
        chk("nom_found", found, 1);
        chk("nom_valid_cycle", cyc, 24);
        chk("nom_fine", l_fine, 60);
        chk("nom_sat", l_sat, 0);
        chk("nom_coarse", l_coarse, 22);
        @(negedge clk);
        chk("nom_idle_after", l_busy, 0);

        // Timeout with no hit
        taps = '0;
        do_reset();
        goto(3); arm = 1'b1; step(); arm = 1'b0;
        pulse_cyc = -1; pulses = 0; busy_cyc = 0; valids = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (timeout) begin
                pulses++;
                if (pulse_cyc < 0) pulse_cyc = cyc;
            end
            if (busy) busy_cyc++;
            if (ts_valid) valids++;
            step();
        end
        chk("to_pulse_cycle", pulse_cyc, 19);
        chk("to_pulse_count", pulses, 1);
        chk("to_armed_cycles", busy_cyc, 16);
        chk("to_no_valid", valids, 0);

        // Saturated line, then a bubbled code
        taps = '0;
        do_reset();
        goto(2); arm = 1'b1; step(); arm = 1'b0;
        goto(4); taps = ones(NTAPS);
        wait_valid(1'b0, 20, found);
        chk("sat_found", found, 1);
        chk("sat_valid_cycle", cyc, 8);
        chk("sat_fine", ts_fine, 200);
        chk("sat_flag", ts_sat, 1);
        chk("sat_coarse", ts_coarse, 6);
        goto(10); taps = '0;
        goto(12); arm = 1'b1; step(); arm = 1'b0;
        v = ones(90); v[5] = 1'b0; v[40] = 1'b0; v[150] = 1'b1;
        goto(14); taps = v;
        wait_valid(1'b0, 20, found);
        chk("bub_found", found, 1);
        chk("bub_fine", ts_fine, 89);
        chk("bub_sat", ts_sat, 0);

        // Lost hits while holding, then accept straight into ARMED
        taps = '0; ts_ready = 1'b0;
        do_reset();
        goto(2); arm = 1'b1; step(); arm = 1'b0;
        goto(6); taps = ones(37);
        wait_valid(1'b0, 20, found);
        chk("hold_found", found, 1);
        chk("hold_valid_cycle", cyc, 10);
        goto(12);
        for (int k = 0; k < 3; k++) begin
            taps = '0; step();
            taps = ones(37); step();
        end
        goto(22);
        ts_ready = 1'b1; arm = 1'b1;
        @(negedge clk);
        chk("hold_lost", lost_cnt, 3);
        chk("hold_fine", ts_fine, 37);
        chk("hold_coarse", ts_coarse, 8);
        chk("hold_still_valid", ts_valid, 1);
        step(); arm = 1'b0;
        @(negedge clk);
        chk("rearm_busy", busy, 1);
        chk("rearm_valid", ts_valid, 0);

        // Reset during ENCODE
        taps = '0; ts_ready = 1'b1;
        do_reset();
        goto(2); arm = 1'b1; step(); arm = 1'b0;
        goto(4); taps = ones(50);
        goto(7); rst = 1'b1; step(); rst = 1'b0;
        @(negedge clk);
        chk("enc_rst_busy", busy, 0);
        chk("enc_rst_valid", ts_valid, 0);
        chk("enc_rst_coarse", ts_coarse, 0);
        chk("enc_rst_fine", ts_fine, 0);
        chk("enc_rst_sat", ts_sat, 0);
        chk("enc_rst_timeout", timeout, 0);
        chk("enc_rst_lost", lost_cnt, 0);
        valids = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            if (ts_valid) valids++;
        end
        chk("enc_rst_no_valid", valids, 0);

        // Randomised traffic
        taps = '0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            arm      = ($urandom_range(0, 3) == 0);
            ts_ready = ($urandom_range(0, 2) != 0);
            rst      = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 5);
                if (r == 0) begin
                    taps = '0;
                end else if (r == 1) begin
                    taps = ones(NTAPS);
                end else begin
                    v = ones($urandom_range(1, NTAPS));
                    if ($urandom_range(0, 2) == 0) v[$urandom_range(0, NTAPS - 1)] ^= 1'b1;
                    taps = v;
                end
            end
            step();
        end
        rst = 1'b0; arm = 1'b0;

        // Coarse counter wrap
        taps = '0; ts_ready = 1'b1;
        do_reset();
        goto(65530); arm = 1'b1; step(); arm = 1'b0;
        goto(65533); taps = ones(120);
        wait_valid(1'b0, 20, found);
        chk("wrap_found", found, 1);
        chk("wrap_coarse_top", ts_coarse, 16'hFFFF);
        chk("wrap_fine", ts_fine, 120);
        goto(65537); taps = '0;
        goto(65540); arm = 1'b1; step(); arm = 1'b0;
        goto(65543); taps = ones(10);
        wait_valid(1'b0, 20, found);
        chk("wrap2_found", found, 1);
        chk("wrap2_coarse", ts_coarse, 9);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdc_measure_ctrl.md
TDC_MEASURE_CTRL -- requirements
Module: tdc_measure_ctrl

Interface
REQ-001 Parameter NTAPS, default 200, SHALL be the number of delay-line taps (4 per CARRY4 stage).
REQ-002 Parameter COARSE_W, default 16, SHALL be the width of the coarse counter.
REQ-003 Parameter TIMEOUT, default 1024, SHALL be the number of ARMED cycles without a hit before the block aborts (range 2..65535).
REQ-004 Derived FINE_W = clog2(NTAPS+1) SHALL be the fine-code width (8 for NTAPS=200).
REQ-005 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-006 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 arm  input  1  SHALL be a request to start one measurement.
REQ-008 taps  input  NTAPS  SHALL be the raw carry-out vector (CO) of the start delay line, asynchronous to clk.
REQ-009 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-010 ts_valid  output  1  SHALL flag a held timestamp.
REQ-011 ts_ready  input  1  SHALL be the downstream accept signal.
REQ-012 ts_coarse  output  COARSE_W  SHALL be the coarse count latched at hit detection.
REQ-013 ts_fine  output  FINE_W  SHALL be the number of '1' taps in the captured thermometer code.
REQ-014 ts_sat  output  1  SHALL flag that all NTAPS taps were '1' (line overrun).
REQ-015 timeout  output  1  SHALL pulse one cycle when TIMEOUT expires.
REQ-016 lost_cnt  output  8  SHALL count hits detected while a timestamp is pending.

Function
REQ-017 taps SHALL pass through two register stages s1, s2; s3 SHALL be a one-bit register holding the previous s2[0].
REQ-018 A hit SHALL be detected in the cycle where s2[0]=1 and s3=0.
REQ-019 A free-running coarse counter SHALL increment every cycle and wrap from 2^COARSE_W-1 to 0.
REQ-020 FSM states SHALL be IDLE, ARMED, ENCODE and HOLD.
REQ-021 IDLE: arm=1 -> ARMED and clear the timeout counter; hits SHALL be ignored and not counted.
REQ-022 ARMED: on hit (cycle D), latch the coarse counter and s2 into a hold register -> ENCODE; the timeout counter SHALL increment each cycle.
REQ-023 ARMED: when the timeout counter reaches TIMEOUT-1 with no hit, timeout SHALL pulse for one cycle -> IDLE.
REQ-024 A hit and a timeout expiry in the same cycle SHALL resolve as a hit, with no timeout pulse.
REQ-025 ENCODE (cycle D+1): popcount of the hold register -> ts_fine; ts_sat = (popcount == NTAPS) -> HOLD.
REQ-026 HOLD: ts_valid=1 from cycle D+2; ts_coarse, ts_fine and ts_sat SHALL stay stable until ts_valid and ts_ready are both high.
REQ-027 On accept, the next state SHALL be ARMED if arm=1 in that cycle, else IDLE.
REQ-028 Hits detected in ENCODE or HOLD SHALL increment lost_cnt, saturating at 255; they SHALL NOT alter held data.
REQ-029 arm SHALL be ignored outside IDLE, except as stated in REQ-027.
REQ-030 Popcount SHALL count all '1' bits, so bubbles are tolerated with no priority encoding.

Reset
REQ-031 rst SHALL force the following at the next edge: state=IDLE, s1=s2=0, s3=0, coarse=0, timeout counter=0, ts_valid=0, ts_coarse=0, ts_fine=0, ts_sat=0, timeout=0, lost_cnt=0, busy=0.
REQ-032 rst mid-measurement SHALL discard any pending timestamp with no ts_valid or timeout pulse; rst SHALL dominate all other inputs.

Verification
REQ-033 Reset, arm at cycle 5, taps step 0->{60 ones} at cycle 20, ts_ready=1 -> ts_valid from cycle 24, ts_fine=60, ts_sat=0, ts_coarse equals the coarse value at cycle 22, then IDLE.
REQ-034 Arm with no hit and TIMEOUT=16 -> timeout pulse exactly 16 cycles after entering ARMED, busy drops the next cycle, ts_valid is never asserted.
REQ-035 Hit with taps all 200 ones -> ts_fine=200, ts_sat=1.
REQ-036 ts_ready=0 during HOLD; three further tap rising edges -> lost_cnt=3 and held data unchanged; ts_ready=1 with arm=1 -> state goes directly to ARMED.
REQ-037 Coarse counter preloaded by running 65534 cycles, then a hit -> ts_coarse wraps correctly (0xFFFF->0x0000 boundary).
REQ-038 rst asserted in ENCODE -> ts_valid stays 0 and all outputs match REQ-031 on the next cycle.
